// File: rtl/lieat_exu_fpu_mq.sv
// lieat_exu_fpu_mq: FPU execute-stage wrapper for an in-order, pipelined,
// valid/ready FP core. It keeps up to DEPTH operations in flight. Each issued
// op's {pc, rd, rdwen} is pushed into a metadata FIFO, and each core result
// is paired with the FIFO head. The block also provides a multi-op flush,
// sticky fflags accumulation and a sticky orphan-result error flag.
//
// Ports
//   clock, reset        clock; asynchronous active-low reset
//   flush_req           pipeline flush request
//   fpu_i_*             issue side: valid/ready, pc, rd, rdwen, operands, infobus
//   core_in_*           to core: valid/ready, core_operands = {imm,src1,src2}, core_infobus
//   core_flush          core kill, asserted in the same cycle as flush_req
//   core_out_*          from core: valid/ready, core_result, core_status
//   fpu_o_*             writeback: valid/ready, pc, wen, rd, data, fflags, flush
//   fflags_acc          sticky OR of retired fflags; fflags_clr clears it
//   busy                at least one op in flight
//   err_orphan          sticky: the core returned a result while nothing was in flight
module lieat_exu_fpu_mq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REGW  = 5,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned INFOW = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush_req,

    input  logic                fpu_i_valid,
    output logic                fpu_i_ready,
    input  logic [XLEN-1:0]     fpu_i_pc,
    input  logic [REGW-1:0]     fpu_i_rd,
    input  logic                fpu_i_rdwen,
    input  logic [XLEN-1:0]     fpu_i_imm,
    input  logic [XLEN-1:0]     fpu_i_src1,
    input  logic [XLEN-1:0]     fpu_i_src2,
    input  logic [INFOW-1:0]    fpu_i_infobus,

    output logic                core_in_valid,
    input  logic                core_in_ready,
    output logic [3*XLEN-1:0]   core_operands,
    output logic [INFOW-1:0]    core_infobus,
    output logic                core_flush,
    input  logic                core_out_valid,
    output logic                core_out_ready,
    input  logic [XLEN-1:0]     core_result,
    input  logic [4:0]          core_status,

    output logic                fpu_o_valid,
    input  logic                fpu_o_ready,
    output logic [XLEN-1:0]     fpu_o_pc,
    output logic                fpu_o_wen,
    output logic [REGW-1:0]     fpu_o_rd,
    output logic [XLEN-1:0]     fpu_o_data,
    output logic [4:0]          fpu_o_fflags,
    output logic                fpu_o_flush,

    output logic [4:0]          fflags_acc,
    input  logic                fflags_clr,
    output logic                busy,
    output logic                err_orphan
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rd;
        logic            rdwen;
    } meta_t;

    meta_t          meta_q [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    meta_t head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Issue path: a combinational pass-through to the core, gated by FIFO space and by flush.
    assign core_in_valid = fpu_i_valid & ~full & ~flush_req;
    assign fpu_i_ready   = core_in_ready & ~full & ~flush_req;
    assign core_operands = {fpu_i_imm, fpu_i_src1, fpu_i_src2};
    assign core_infobus  = fpu_i_infobus;
    assign core_flush    = flush_req;
    assign push          = fpu_i_valid & fpu_i_ready;

    // Retire path: the head metadata is paired with the core result. An empty FIFO
    // or an active flush keeps core_out_ready high so that stray results drain.
    assign head           = meta_q[rd_ptr];
    assign fpu_o_valid    = core_out_valid & ~empty & ~flush_req;
    assign core_out_ready = (fpu_o_ready & ~empty) | empty | flush_req;
    assign pop            = fpu_o_valid & fpu_o_ready;
    assign fpu_o_pc       = head.pc;
    assign fpu_o_rd       = head.rd;
    assign fpu_o_wen      = head.rdwen;
    assign fpu_o_data     = core_result;
    assign fpu_o_fflags   = core_status;
    assign fpu_o_flush    = flush_req & ~empty;
    assign busy           = ~empty;

    // Metadata storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '0;
            end
        end else if (push) begin
            meta_q[wr_ptr] <= '{pc: fpu_i_pc, rd: fpu_i_rd, rdwen: fpu_i_rdwen};
        end
    end

    // Pointers and occupancy; flush discards every in-flight op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky fflags: a clear drops the old bits, but a same-cycle retire still sets its bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fflags_acc <= '0;
        end else if (fflags_clr || pop) begin
            fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | (pop ? core_status : 5'b0);
        end
    end

    // Orphan detector: the core delivered a result that nothing is waiting for
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_orphan <= 1'b0;
        end else if (core_out_valid && empty && !flush_req) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lieat_exu_fpu_mq.sv
// Testbench for lieat_exu_fpu_mq. A behavioural core model returns results in
// order after a programmable latency. A scoreboard queue holds the expected
// writeback of every op accepted at issue.
module tb_lieat_exu_fpu_mq;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned INFOW = 32;

    logic                clock;
    logic                reset;
    logic                flush_req;
    logic                fpu_i_valid;
    logic                fpu_i_ready;
    logic [XLEN-1:0]     fpu_i_pc;
    logic [REGW-1:0]     fpu_i_rd;
    logic                fpu_i_rdwen;
    logic [XLEN-1:0]     fpu_i_imm;
    logic [XLEN-1:0]     fpu_i_src1;
    logic [XLEN-1:0]     fpu_i_src2;
    logic [INFOW-1:0]    fpu_i_infobus;
    logic                core_in_valid;
    logic                core_in_ready;
    logic [3*XLEN-1:0]   core_operands;
    logic [INFOW-1:0]    core_infobus;
    logic                core_flush;
    logic                core_out_valid;
    logic                core_out_ready;
    logic [XLEN-1:0]     core_result;
    logic [4:0]          core_status;
    logic                fpu_o_valid;
    logic                fpu_o_ready;
    logic [XLEN-1:0]     fpu_o_pc;
    logic                fpu_o_wen;
    logic [REGW-1:0]     fpu_o_rd;
    logic [XLEN-1:0]     fpu_o_data;
    logic [4:0]          fpu_o_fflags;
    logic                fpu_o_flush;
    logic [4:0]          fflags_acc;
    logic                fflags_clr;
    logic                busy;
    logic                err_orphan;

    lieat_exu_fpu_mq #(.XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .INFOW(INFOW)) dut (
        .clock(clock), .reset(reset), .flush_req(flush_req),
        .fpu_i_valid(fpu_i_valid), .fpu_i_ready(fpu_i_ready), .fpu_i_pc(fpu_i_pc),
        .fpu_i_rd(fpu_i_rd), .fpu_i_rdwen(fpu_i_rdwen), .fpu_i_imm(fpu_i_imm),
        .fpu_i_src1(fpu_i_src1), .fpu_i_src2(fpu_i_src2), .fpu_i_infobus(fpu_i_infobus),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_operands(core_operands), .core_infobus(core_infobus), .core_flush(core_flush),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_result(core_result), .core_status(core_status),
        .fpu_o_valid(fpu_o_valid), .fpu_o_ready(fpu_o_ready), .fpu_o_pc(fpu_o_pc),
        .fpu_o_wen(fpu_o_wen), .fpu_o_rd(fpu_o_rd), .fpu_o_data(fpu_o_data),
        .fpu_o_fflags(fpu_o_fflags), .fpu_o_flush(fpu_o_flush),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rd;
        logic            wen;
        logic [XLEN-1:0] res;
        logic [4:0]      st;
        int              t;
    } op_t;

    op_t        sb[$];
    op_t        core_q[$];
    int         checks;
    int         errors;
    int         cyc_n;
    logic       core_en;
    int         core_lat;
    logic [4:0] next_st;
    logic [4:0] m_acc;
    logic       m_orphan;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the core model, check outputs that respond combinationally,
    // update the model, cross the edge, then check the registered state.
    task automatic tick();
        logic exp_full, exp_ir, exp_ov, exp_cor, fire_i, fire_o, was_empty;
        logic [4:0] pop_st;
        op_t e;
        op_t d;
        pop_st = 5'b0;
        if (core_en && core_q.size() > 0 && (cyc_n - core_q[0].t) >= core_lat) begin
            core_out_valid = 1'b1;
            core_result    = core_q[0].res;
            core_status    = core_q[0].st;
        end else begin
            core_out_valid = 1'b0;
            core_result    = '0;
            core_status    = '0;
        end
        fpu_i_imm     = $urandom();
        fpu_i_src1    = $urandom();
        fpu_i_src2    = $urandom();
        fpu_i_infobus = $urandom();
        #1;
        was_empty = (sb.size() == 0);
        exp_full  = (sb.size() == DEPTH);
        exp_ir    = core_in_ready && !exp_full && !flush_req;
        exp_ov    = core_out_valid && !was_empty && !flush_req;
        exp_cor   = (fpu_o_ready && !was_empty) || was_empty || flush_req;
        chk("fpu_i_ready", 128'(fpu_i_ready), 128'(exp_ir));
        chk("core_in_valid", 128'(core_in_valid), 128'(fpu_i_valid && !exp_full && !flush_req));
        chk("fpu_o_valid", 128'(fpu_o_valid), 128'(exp_ov));
        chk("core_out_ready", 128'(core_out_ready), 128'(exp_cor));
        chk("core_flush", 128'(core_flush), 128'(flush_req));
        chk("fpu_o_flush", 128'(fpu_o_flush), 128'(flush_req && !was_empty));
        chk("core_operands", 128'(core_operands), 128'({fpu_i_imm, fpu_i_src1, fpu_i_src2}));
        chk("core_infobus", 128'(core_infobus), 128'(fpu_i_infobus));
        fire_i = fpu_i_valid && exp_ir;
        fire_o = exp_ov && fpu_o_ready;
        if (fire_o) begin
            e = sb.pop_front();
            pop_st = e.st;
            chk("o_pc", 128'(fpu_o_pc), 128'(e.pc));
            chk("o_rd", 128'(fpu_o_rd), 128'(e.rd));
            chk("o_wen", 128'(fpu_o_wen), 128'(e.wen));
            chk("o_data", 128'(fpu_o_data), 128'(e.res));
            chk("o_fflags", 128'(fpu_o_fflags), 128'(e.st));
        end
        if (core_out_valid && exp_cor) begin
            d = core_q.pop_front();
        end
        if (core_out_valid && was_empty && !flush_req) begin
            m_orphan = 1'b1;
        end
        if (fire_i) begin
            e = '{pc: fpu_i_pc, rd: fpu_i_rd, wen: fpu_i_rdwen,
                  res: fpu_i_pc ^ 32'h5a5a_0000, st: next_st, t: cyc_n};
            sb.push_back(e);
            core_q.push_back(e);
        end
        if (flush_req) begin
            sb.delete();
            core_q.delete();
        end
        m_acc = (fflags_clr ? 5'b0 : m_acc) | pop_st;
        @(posedge clock);
        #1;
        cyc_n++;
        chk("fflags_acc", 128'(fflags_acc), 128'(m_acc));
        chk("err_orphan", 128'(err_orphan), 128'(m_orphan));
        chk("busy", 128'(busy), 128'(sb.size() != 0));
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [REGW-1:0] rd,
                         input logic wen, input logic [4:0] st);
        fpu_i_valid = 1'b1;
        fpu_i_pc    = pc;
        fpu_i_rd    = rd;
        fpu_i_rdwen = wen;
        next_st     = st;
        tick();
        fpu_i_valid = 1'b0;
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0; flush_req = 1'b0;
        fpu_i_valid = 1'b0; fpu_i_pc = '0; fpu_i_rd = '0; fpu_i_rdwen = 1'b0;
        fpu_i_imm = '0; fpu_i_src1 = '0; fpu_i_src2 = '0; fpu_i_infobus = '0;
        core_in_ready = 1'b1; core_out_valid = 1'b0; core_result = '0; core_status = '0;
        fpu_o_ready = 1'b1; fflags_clr = 1'b0;
        checks = 0; errors = 0; cyc_n = 0;
        core_en = 1'b0; core_lat = 0; next_st = '0; m_acc = '0; m_orphan = 1'b0;

        // Reset state
        #1;
        chk("rst_o_valid", 128'(fpu_o_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_core_flush", 128'(core_flush), 128'(0));
        chk("rst_fflags", 128'(fflags_acc), 128'(0));
        chk("rst_orphan", 128'(err_orphan), 128'(0));
        #21 reset = 1'b1;

        // Fill to DEPTH while the core holds its outputs; a fifth op must stall
        core_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'h200 + 32'(4 * i), 5'(i + 1), 1'b1, 5'b0);
        end
        fpu_i_valid = 1'b1; fpu_i_pc = 32'h210; fpu_i_rd = 5'd9; fpu_i_rdwen = 1'b0;
        #1;
        chk("fifth_ready", 128'(fpu_i_ready), 128'(0));
        chk("full_busy", 128'(busy), 128'(1));
        tick();
        // Core presents a result while writeback is stalled
        core_en = 1'b1; core_lat = 0; fpu_o_ready = 1'b0;
        tick();
        // Pop while full: the slot frees only on the next cycle
        fpu_o_ready = 1'b1;
        #1;
        chk("full_pop_ready", 128'(fpu_i_ready), 128'(0));
        tick();
        chk("after_pop_ready", 128'(fpu_i_ready), 128'(1));
        tick();
        fpu_i_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Back-to-back issue and retire, core latency 2
        core_lat = 2;
        issue(32'h100, 5'd3, 1'b1, 5'b0);
        issue(32'h104, 5'd4, 1'b0, 5'b0);
        issue(32'h108, 5'd5, 1'b1, 5'b0);
        for (int i = 0; i < 4; i++) tick();

        // Flush with three ops in flight
        core_en = 1'b0;
        issue(32'h300, 5'd6, 1'b1, 5'b0);
        issue(32'h304, 5'd7, 1'b1, 5'b0);
        issue(32'h308, 5'd8, 1'b1, 5'b0);
        core_en = 1'b1; core_lat = 0;
        flush_req = 1'b1; fpu_i_valid = 1'b1; fpu_i_pc = 32'h30c;
        #1;
        chk("flush_core_flush", 128'(core_flush), 128'(1));
        chk("flush_o_flush", 128'(fpu_o_flush), 128'(1));
        tick();
        chk("flush_busy", 128'(busy), 128'(0));
        flush_req = 1'b0; fpu_i_valid = 1'b0;
        for (int i = 0; i < 2; i++) tick();

        // fflags accumulation, then a clear racing a retire
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0; core_lat = 1;
        issue(32'h400, 5'd10, 1'b1, 5'b00001);
        issue(32'h404, 5'd11, 1'b1, 5'b10000);
        for (int i = 0; i < 3; i++) tick();
        chk("acc_or", 128'(fflags_acc), 128'(5'b10001));
        core_en = 1'b0;
        issue(32'h408, 5'd12, 1'b1, 5'b00100);
        core_en = 1'b1; core_lat = 0; fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("acc_clr_set", 128'(fflags_acc), 128'(5'b00100));

        // Reset asserted with two ops in flight; their late results become orphans
        core_en = 1'b0;
        issue(32'h500, 5'd13, 1'b1, 5'b0);
        issue(32'h504, 5'd14, 1'b1, 5'b0);
        #2 reset = 1'b0;
        core_out_valid = 1'b1; core_result = 32'h1234;
        #1;
        chk("rst_mid_o_valid", 128'(fpu_o_valid), 128'(0));
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_acc", 128'(fflags_acc), 128'(0));
        sb.delete(); m_acc = '0; m_orphan = 1'b0;
        #2 reset = 1'b1;
        core_out_valid = 1'b0;
        core_en = 1'b1; core_lat = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("orphan_set", 128'(err_orphan), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
